// File: rtl/param_microcoded_cpu_pkg.sv
// Shared types and instruction-field helpers for the parametrised microcoded CPU.
// Field offsets are functions because the package cannot see the core's parameters.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_MOV  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_INC  = 4'h5,
        OP_DEC  = 4'h6,
        OP_AND  = 4'h7,
        OP_XOR  = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_JNZ  = 4'hB,
        OP_JC   = 4'hC,
        OP_JNC  = 4'hD,
        OP_HALT = 4'hE,
        OP_NOP2 = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

    localparam int OP_W = 4;

    function automatic int instr_w(input int data_w, input int rsel_w);
        return OP_W + 2 * rsel_w + data_w;
    endfunction

    function automatic int op_lsb(input int data_w, input int rsel_w);
        return data_w + 2 * rsel_w;
    endfunction

    function automatic int rd_lsb(input int data_w, input int rsel_w);
        return data_w + rsel_w;
    endfunction

    function automatic int rs_lsb(input int data_w);
        return data_w;
    endfunction

    localparam int IMM_LSB = 0;

endpackage

// File: rtl/param_microcoded_cpu_alu.sv
// Combinational ALU for the flag-setting ops (ADD..XOR); carry bit doubles as borrow for SUB/DEC.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              zf,
    output logic              cf
);

    logic [DATA_W:0] ext_s;
    logic [DATA_W:0] one_s;

    assign one_s = {{DATA_W{1'b0}}, 1'b1};

    // One extra bit catches carry-out, and the wrapped top bit of a subtraction is the borrow.
    always_comb begin
        ext_s = {(DATA_W + 1){1'b0}};
        case (opcode_e'(op))
            OP_ADD:  ext_s = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext_s = {1'b0, a} - {1'b0, b};
            OP_INC:  ext_s = {1'b0, a} + one_s;
            OP_DEC:  ext_s = {1'b0, a} - one_s;
            OP_AND:  ext_s = {1'b0, a & b};
            OP_XOR:  ext_s = {1'b0, a ^ b};
            default: ext_s = {(DATA_W + 1){1'b0}};
        endcase
    end

    assign r  = ext_s[DATA_W-1:0];
    assign cf = ext_s[DATA_W];
    assign zf = (ext_s[DATA_W-1:0] == {DATA_W{1'b0}});

endmodule

// File: rtl/param_microcoded_cpu.sv
// Multi-cycle (FETCH/EXEC) CPU core with run-time loadable program memory,
// register file, flags and a combinational debug read port.
module param_microcoded_cpu
    import cpu_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NREGS   = 4,
    parameter  int PC_W    = 6,
    localparam int RSEL_W  = $clog2(NREGS),
    localparam int INSTR_W = instr_w(DATA_W, RSEL_W)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [RSEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [PC_W-1:0]    pc,
    output logic               zf,
    output logic               cf,
    output logic               busy,
    output logic               halted
);

    localparam int IMEM_D  = 2 ** PC_W;
    localparam int OP_LSB  = op_lsb(DATA_W, RSEL_W);
    localparam int RD_LSB  = rd_lsb(DATA_W, RSEL_W);
    localparam int RS_LSB  = rs_lsb(DATA_W);

    logic [INSTR_W-1:0] imem_q [IMEM_D];
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [DATA_W-1:0]  regs_d [NREGS];

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               zf_q, zf_d;
    logic               cf_q, cf_d;
    logic               halted_q, halted_d;

    logic [3:0]         op_bits_s;
    opcode_e            op_s;
    logic [RSEL_W-1:0]  rd_s, rs_s;
    logic [DATA_W-1:0]  imm_s;
    logic [PC_W-1:0]    tgt_s, pc_inc_s;
    logic [DATA_W-1:0]  alu_r_s;
    logic               alu_zf_s, alu_cf_s;

    assign op_bits_s = ir_q[OP_LSB +: OP_W];
    assign op_s      = opcode_e'(op_bits_s);
    assign rd_s      = ir_q[RD_LSB +: RSEL_W];
    assign rs_s      = ir_q[RS_LSB +: RSEL_W];
    assign imm_s     = ir_q[IMM_LSB +: DATA_W];
    assign tgt_s     = PC_W'(imm_s);
    assign pc_inc_s  = pc_q + {{(PC_W - 1){1'b0}}, 1'b1};

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op (op_bits_s),
        .a  (regs_q[rd_s]),
        .b  (regs_q[rs_s]),
        .r  (alu_r_s),
        .zf (alu_zf_s),
        .cf (alu_cf_s)
    );

    // FSM state register (busy is flopped alongside so it is glitch-free).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? FETCH : IDLE;
            FETCH:   state_d = EXEC;
            EXEC:    state_d = (op_s == OP_HALT) ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, registered on the next edge.
    always_comb begin
        busy_d = 1'b0;
        if (state_d != IDLE) begin
            busy_d = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
    end

    // Program memory: only writable while the core is idle; not reset.
    always_ff @(posedge clock) begin
        if (prog_we && (state_q == IDLE)) begin
            imem_q[prog_addr] <= prog_data;
        end
    end

    // Datapath next state: instruction register, pc, registers, flags and halt pulse.
    always_comb begin
        regs_d   = regs_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        zf_d     = zf_q;
        cf_d     = cf_q;
        halted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    pc_d = {PC_W{1'b0}};
                end else begin
                    pc_d = pc_q;
                end
            end
            FETCH: ir_d = imem_q[pc_q];
            EXEC: begin
                pc_d = pc_inc_s;
                case (op_s)
                    OP_LDI: regs_d[rd_s] = imm_s;
                    OP_MOV: regs_d[rd_s] = regs_q[rs_s];
                    OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_XOR: begin
                        regs_d[rd_s] = alu_r_s;
                        zf_d         = alu_zf_s;
                        cf_d         = alu_cf_s;
                    end
                    OP_JMP:  pc_d = tgt_s;
                    OP_JZ:   pc_d = zf_q  ? tgt_s : pc_inc_s;
                    OP_JNZ:  pc_d = !zf_q ? tgt_s : pc_inc_s;
                    OP_JC:   pc_d = cf_q  ? tgt_s : pc_inc_s;
                    OP_JNC:  pc_d = !cf_q ? tgt_s : pc_inc_s;
                    OP_HALT: begin
                        pc_d     = pc_q;
                        halted_d = 1'b1;
                    end
                    default: pc_d = pc_inc_s;
                endcase
            end
            default: pc_d = pc_q;
        endcase
    end

    // Datapath registers; reset aborts any in-flight EXEC before it commits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q     <= {PC_W{1'b0}};
            ir_q     <= {INSTR_W{1'b0}};
            zf_q     <= 1'b0;
            cf_q     <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            zf_q     <= zf_d;
            cf_q     <= cf_d;
            halted_q <= halted_d;
            regs_q   <= regs_d;
        end
    end

    assign dbg_data = regs_q[dbg_sel];
    assign pc       = pc_q;
    assign zf       = zf_q;
    assign cf       = cf_q;
    assign busy     = busy_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_param_microcoded_cpu.sv
// Directed self-checking bench for param_microcoded_cpu at default parameters.
module tb_param_microcoded_cpu;

    localparam logic [3:0] LDI = 4'h1, MOV = 4'h2, ADD = 4'h3, SUB = 4'h4, INC = 4'h5;
    localparam logic [3:0] DEC = 4'h6, AND_ = 4'h7, XOR_ = 4'h8, JMP = 4'h9, JNZ = 4'hB;
    localparam logic [3:0] JC = 4'hC, HALT = 4'hE, NOP = 4'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [5:0]  prog_addr = 6'd0;
    logic [15:0] prog_data = 16'd0;
    logic [1:0]  dbg_sel = 2'd0;
    logic [7:0]  dbg_data;
    logic [5:0]  pc;
    logic        zf, cf, busy, halted;

    int checks = 0;
    int errors = 0;
    int cyc;

    param_microcoded_cpu #(.DATA_W(8), .NREGS(4), .PC_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .pc        (pc),
        .zf        (zf),
        .cf        (cf),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, {24'd0, dbg_data}, {24'd0, exp});
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] w);
        @(negedge clock);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = w;
        @(negedge clock);
        prog_we   = 1'b0;
    endtask

    // Pulse run (optionally with a same-cycle write), optionally poke run/prog_we while busy,
    // and count clock edges after the run edge until halted is seen.
    task automatic start_run(input logic wr, input logic [5:0] wa, input logic [15:0] wd,
                             input logic disturb, output int cycles);
        @(negedge clock);
        run       = 1'b1;
        prog_we   = wr;
        prog_addr = wa;
        prog_data = wd;
        @(negedge clock);
        run     = 1'b0;
        prog_we = 1'b0;
        cycles  = 0;
        while (cycles < 400) begin
            if (disturb && cycles < 4) begin
                run       = 1'b1;
                prog_we   = 1'b1;
                prog_addr = 6'd3;
                prog_data = mk(LDI, 2'd1, 2'd0, 8'h09);
            end else begin
                run     = 1'b0;
                prog_we = 1'b0;
            end
            @(posedge clock);
            cycles++;
            @(negedge clock);
            if (halted) break;
        end
        run     = 1'b0;
        prog_we = 1'b0;
        check("halt_seen", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_pc", {26'd0, pc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_flags", {30'd0, zf, cf}, 32'd0);
        check_reg("rst_r0", 2'd0, 8'h00);
        check_reg("rst_r3", 2'd3, 8'h00);
        @(negedge clock);
        reset = 1'b0;

        // Test 1: basic add
        write_word(6'd0, mk(LDI, 2'd0, 2'd0, 8'h05));
        write_word(6'd1, mk(LDI, 2'd1, 2'd0, 8'h03));
        write_word(6'd2, mk(ADD, 2'd0, 2'd1, 8'h00));
        write_word(6'd3, mk(HALT, 2'd0, 2'd0, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check("t1_cycles", cyc, 32'd8);
        check_reg("t1_r0", 2'd0, 8'h08);
        check("t1_flags", {30'd0, zf, cf}, 32'd0);
        check("t1_pc", {26'd0, pc}, 32'd3);
        check("t1_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("t1_halt_pulse", {31'd0, halted}, 32'd0);

        // Test 2: INC carry-out, then SUB borrow from zero
        write_word(6'd0, mk(LDI, 2'd0, 2'd0, 8'hFF));
        write_word(6'd1, mk(INC, 2'd0, 2'd0, 8'h00));
        write_word(6'd2, mk(HALT, 2'd0, 2'd0, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check_reg("t2_r0_inc", 2'd0, 8'h00);
        check("t2_flags_inc", {30'd0, zf, cf}, 32'd3);
        write_word(6'd0, mk(LDI, 2'd1, 2'd0, 8'h01));
        write_word(6'd1, mk(SUB, 2'd0, 2'd1, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check_reg("t2_r0_sub", 2'd0, 8'hFF);
        check("t2_flags_sub", {30'd0, zf, cf}, 32'd1);

        // Test 3: countdown loop
        write_word(6'd0, mk(LDI, 2'd2, 2'd0, 8'h03));
        write_word(6'd1, mk(DEC, 2'd2, 2'd0, 8'h00));
        write_word(6'd2, mk(JNZ, 2'd0, 2'd0, 8'h01));
        write_word(6'd3, mk(HALT, 2'd0, 2'd0, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check("t3_cycles", cyc, 32'd16);
        check_reg("t3_r2", 2'd2, 8'h00);
        check("t3_flags", {30'd0, zf, cf}, 32'd2);
        check("t3_pc", {26'd0, pc}, 32'd3);

        // Test 4: jump to the last address and wrap to 0, where JC now takes
        write_word(6'd0, mk(JC, 2'd0, 2'd0, 8'h05));
        write_word(6'd1, mk(LDI, 2'd3, 2'd0, 8'hFF));
        write_word(6'd2, mk(INC, 2'd3, 2'd0, 8'h00));
        write_word(6'd3, mk(JMP, 2'd0, 2'd0, 8'h3F));
        write_word(6'd5, mk(HALT, 2'd0, 2'd0, 8'h00));
        write_word(6'd63, mk(NOP, 2'd0, 2'd0, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check("t4_cycles", cyc, 32'd14);
        check("t4_pc", {26'd0, pc}, 32'd5);
        check_reg("t4_r3", 2'd3, 8'h00);

        // Test 5: run/prog_we while busy are ignored; same-cycle write+run in IDLE
        write_word(6'd0, mk(LDI, 2'd1, 2'd0, 8'h07));
        write_word(6'd1, mk(NOP, 2'd0, 2'd0, 8'h00));
        write_word(6'd2, mk(NOP, 2'd0, 2'd0, 8'h00));
        write_word(6'd3, mk(NOP, 2'd0, 2'd0, 8'h00));
        write_word(6'd4, mk(HALT, 2'd0, 2'd0, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b1, cyc);
        check("t5_cycles", cyc, 32'd10);
        check_reg("t5_r1", 2'd1, 8'h07);
        check("t5_pc", {26'd0, pc}, 32'd4);
        start_run(1'b1, 6'd0, mk(LDI, 2'd2, 2'd0, 8'h5A), 1'b0, cyc);
        check("t5_same_cycles", cyc, 32'd10);
        check_reg("t5_r2", 2'd2, 8'h5A);
        check_reg("t5_r1_kept", 2'd1, 8'h07);

        // Test 6: reset during EXEC of ADD r0,r1, then rerun
        write_word(6'd0, mk(LDI, 2'd0, 2'd0, 8'h05));
        write_word(6'd1, mk(LDI, 2'd1, 2'd0, 8'h03));
        write_word(6'd2, mk(ADD, 2'd0, 2'd1, 8'h00));
        write_word(6'd3, mk(HALT, 2'd0, 2'd0, 8'h00));
        @(negedge clock);
        run = 1'b1;
        @(negedge clock);
        run = 1'b0;
        repeat (5) @(negedge clock);
        check_reg("t6_r0_pre", 2'd0, 8'h05);
        reset = 1'b1;
        #1;
        check_reg("t6_r0", 2'd0, 8'h00);
        check("t6_pc", {26'd0, pc}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check("t6_cycles", cyc, 32'd8);
        check_reg("t6_r0_rerun", 2'd0, 8'h08);
        check("t6_pc_rerun", {26'd0, pc}, 32'd3);

        // Logic ops, MOV and rd==rs
        write_word(6'd0, mk(LDI, 2'd3, 2'd0, 8'hF0));
        write_word(6'd1, mk(LDI, 2'd2, 2'd0, 8'h3C));
        write_word(6'd2, mk(AND_, 2'd3, 2'd2, 8'h00));
        write_word(6'd3, mk(XOR_, 2'd2, 2'd3, 8'h00));
        write_word(6'd4, mk(MOV, 2'd0, 2'd2, 8'h00));
        write_word(6'd5, mk(ADD, 2'd1, 2'd1, 8'h00));
        write_word(6'd6, mk(HALT, 2'd0, 2'd0, 8'h00));
        start_run(1'b0, 6'd0, 16'd0, 1'b0, cyc);
        check_reg("t7_r3_and", 2'd3, 8'h30);
        check_reg("t7_r2_xor", 2'd2, 8'h0C);
        check_reg("t7_r0_mov", 2'd0, 8'h0C);
        check_reg("t7_r1_dbl", 2'd1, 8'h06);
        check("t7_flags", {30'd0, zf, cf}, 32'd0);
        check("t7_pc", {26'd0, pc}, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
